// File: rtl/descrambler_pkg.sv
// Shared types, constants and helpers for the LLR descrambler and Gold sequence generator.
package descrambler_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWarmup,
    StRun
  } state_e;

  localparam int unsigned LfsrW     = 31;
  localparam logic [LfsrW-1:0] X1Init = 31'h1;
  localparam int unsigned NcDefault = 1600;

  // Two's complement negation of a dw-bit value held sign-extended in 32 bits.
  // The most negative value maps to the most positive one instead of overflowing.
  function automatic logic signed [31:0] sat_negate(input logic signed [31:0] val,
                                                    input int unsigned dw);
    logic signed [31:0] min_val;
    min_val = -(32'sd1 <<< (dw - 1));
    if (val == min_val) begin
      return -(min_val + 32'sd1);
    end
    return -val;
  endfunction

endpackage

// File: rtl/gold_seq_gen.sv
// Length-31 Gold sequence generator: two LFSRs x1/x2, bit 0 is the oldest element.
module gold_seq_gen
  import descrambler_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [LfsrW-1:0] x2_init,
  output logic             c
);

  logic [LfsrW-1:0] x1_q, x1_d;
  logic [LfsrW-1:0] x2_q, x2_d;

  // Next LFSR state: load wins over step.
  always_comb begin
    x1_d = x1_q;
    x2_d = x2_q;
    if (load) begin
      x1_d = X1Init;
      x2_d = x2_init;
    end else if (step) begin
      x1_d = {x1_q[3] ^ x1_q[0], x1_q[LfsrW-1:1]};
      x2_d = {x2_q[3] ^ x2_q[2] ^ x2_q[1] ^ x2_q[0], x2_q[LfsrW-1:1]};
    end
  end

  // LFSR state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x1_q <= '0;
      x2_q <= '0;
    end else begin
      x1_q <= x1_d;
      x2_q <= x2_d;
    end
  end

  assign c = x1_q[0] ^ x2_q[0];

endmodule

// File: rtl/llr_descrambler.sv
// LLR descrambler: negates each LLR whose Gold sequence bit is 1, with a warm-up
// fast-forward of NC sequence steps after every c_init load.
module llr_descrambler
  import descrambler_pkg::*;
#(
  parameter int unsigned LLR_DW = 8,
  parameter int unsigned NC     = NcDefault
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [LfsrW-1:0]  c_init_i,
  input  logic              c_init_valid_i,
  input  logic [LLR_DW-1:0] s_axis_in_tdata,
  input  logic [1:0]        s_axis_in_tuser,
  input  logic              s_axis_in_tlast,
  input  logic              s_axis_in_tvalid,
  output logic              s_axis_in_tready,
  output logic [LLR_DW-1:0] m_axis_out_tdata,
  output logic [1:0]        m_axis_out_tuser,
  output logic              m_axis_out_tlast,
  output logic              m_axis_out_tvalid,
  input  logic              m_axis_out_tready,
  output logic              busy_o
);

  // NC=0 still needs a 1-bit counter so the declaration stays legal.
  localparam int unsigned CntW = (NC > 0) ? $clog2(NC + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(NC - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              seq_load, seq_step, seq_c;
  logic              in_ready, accept;
  logic [LLR_DW-1:0] out_data_q;
  logic [1:0]        out_user_q;
  logic              out_last_q, out_valid_q;
  logic signed [31:0] llr_ext;
  logic [LLR_DW-1:0] neg_llr, desc_llr;

  gold_seq_gen u_gold_seq_gen (
    .clk     (clk_i),
    .rst     (reset_i),
    .load    (seq_load),
    .step    (seq_step),
    .x2_init (c_init_i),
    .c       (seq_c)
  );

  assign llr_ext  = 32'($signed(s_axis_in_tdata));
  assign neg_llr  = LLR_DW'(sat_negate(llr_ext, LLR_DW));
  assign desc_llr = seq_c ? neg_llr : s_axis_in_tdata;

  // FSM next state, warm-up counting and input handshake; reload overrides everything.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    seq_load = 1'b0;
    seq_step = 1'b0;
    in_ready = 1'b0;
    accept   = 1'b0;
    if (c_init_valid_i) begin
      seq_load = 1'b1;
      cnt_d    = '0;
      state_d  = (NC == 0) ? StRun : StWarmup;
    end else begin
      unique case (state_q)
        StIdle: begin
        end
        StWarmup: begin
          seq_step = 1'b1;
          cnt_d    = cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            state_d = StRun;
          end
        end
        StRun: begin
          in_ready = !out_valid_q || m_axis_out_tready;
          accept   = in_ready && s_axis_in_tvalid;
          if (accept) begin
            seq_step = 1'b1;
            if (s_axis_in_tlast) begin
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM state and warm-up counter registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output register: filled on acceptance, emptied on transfer, otherwise held.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      out_data_q  <= '0;
      out_user_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_data_q  <= desc_llr;
      out_user_q  <= s_axis_in_tuser;
      out_last_q  <= s_axis_in_tlast;
      out_valid_q <= 1'b1;
    end else if (m_axis_out_tready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign s_axis_in_tready  = in_ready;
  assign m_axis_out_tdata  = out_data_q;
  assign m_axis_out_tuser  = out_user_q;
  assign m_axis_out_tlast  = out_last_q;
  assign m_axis_out_tvalid = out_valid_q;
  assign busy_o            = (state_q == StWarmup) || (state_q == StRun);

endmodule
